// File: rtl/m72_sample_player.sv
`timescale 1ns / 1ps
// m72_sample_player
//
// Sample port responder for the M72/M84 sound CPU. It holds the sample ROM pointer and
// prefetches the ROM byte at that pointer from SDRAM. It also drives the 8-bit sample DAC,
// which appears to the mixer as a 16-bit signed channel.
//
// Parameters:
//   ROM_BASE       SDRAM byte address of sample ROM byte 0
//   PTR_W          sample pointer width (14..21), wraps modulo 2^PTR_W
//
// Ports:
//   CLK_32M        system clock
//   reset_n        synchronous active-low reset
//   sample_addr_wr pointer load strobes: bit0 low byte (ptr[12:5]), bit1 high byte (ptr[W-1:13])
//   sample_addr    pointer load data
//   sample_inc     latch sample_out into the DAC and advance the pointer
//   sample_out     unsigned DAC value
//   sample_in      ROM byte at the current pointer
//   sample_ready   sample_in matches the pointer and no fetch is outstanding
//   rom_addr       SDRAM byte address (ROM_BASE + pointer), held during a fetch
//   rom_req        SDRAM read request level, held until rom_ack
//   rom_ack        SDRAM one-cycle acknowledge, rom_data valid with it
//   rom_data       SDRAM read data
//   audio_out      signed DAC output, 0x80 maps to 0
//
// Build option: define M72_SAMPLE_FILTER_EN to low-pass audio_out with a one-pole filter
// updated every 256 clocks. Without it audio_out is the raw DAC value.
module m72_sample_player #(
  parameter logic [24:0] ROM_BASE = 25'h0,
  parameter int unsigned PTR_W    = 18
) (
  input  logic        CLK_32M,
  input  logic        reset_n,
  input  logic [1:0]  sample_addr_wr,
  input  logic [7:0]  sample_addr,
  input  logic        sample_inc,
  input  logic [7:0]  sample_out,
  output logic [7:0]  sample_in,
  output logic        sample_ready,
  output logic [24:0] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic [15:0] audio_out
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e             state_q;
  logic               dirty_q;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               ptr_evt;
  logic [7:0]         dac_q;
  logic [15:0]        audio_raw;

  // Bits of sample_addr above PTR_W-14 are ignored by high loads.
  logic unused_sample_addr;
  assign unused_sample_addr = ^sample_addr;

  // Pointer events apply in order: low load, high load, increment.
  always_comb begin
    ptr_d = ptr_q;
    if (sample_addr_wr[0]) begin
      ptr_d[12:5] = sample_addr;
      ptr_d[4:0]  = 5'd0;
    end
    if (sample_addr_wr[1]) begin
      ptr_d[PTR_W-1:13] = sample_addr[PTR_W-14:0];
    end
    if (sample_inc) begin
      ptr_d = ptr_d + PTR_W'(1);
    end
  end

  assign ptr_evt = (|sample_addr_wr) | sample_inc;

  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      ptr_q <= '0;
      dac_q <= 8'h80;
    end else begin
      ptr_q <= ptr_d;
      if (sample_inc) begin
        dac_q <= sample_out;
      end
    end
  end

  // Fetch FSM. dirty means the pointer moved since the last fetch was launched; a fetch
  // completing while dirty is discarded and the IDLE state immediately refetches.
  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      dirty_q   <= 1'b1;
      rom_req   <= 1'b0;
      rom_addr  <= ROM_BASE;
      sample_in <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dirty_q) begin
            rom_addr <= ROM_BASE + 25'(ptr_q);
            rom_req  <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (rom_ack) begin
            rom_req <= 1'b0;
            state_q <= StIdle;
            if (!dirty_q) begin
              sample_in <= rom_data;
            end
          end
        end
      endcase
      // A pointer event in the launch cycle keeps dirty set, so the new pointer is refetched.
      if (ptr_evt) begin
        dirty_q <= 1'b1;
      end else if (state_q == StIdle) begin
        dirty_q <= 1'b0;
      end
    end
  end

  assign sample_ready = (state_q == StIdle) && !dirty_q;

  assign audio_raw = {dac_q ^ 8'h80, 8'h00};

`ifdef M72_SAMPLE_FILTER_EN
  logic [7:0]          tick_cnt_q;
  logic signed [15:0]  y_q, y_d;
  logic signed [16:0]  diff;
  logic signed [16:0]  step;
  logic signed [17:0]  sum;

  always_comb begin
    diff = {audio_raw[15], audio_raw} - {y_q[15], y_q};
    step = diff >>> 3;
    sum  = {{2{y_q[15]}}, y_q} + {step[16], step};
    if (sum > 18'sd32767) begin
      y_d = 16'sh7FFF;
    end else if (sum < -18'sd32768) begin
      y_d = 16'sh8000;
    end else begin
      y_d = sum[15:0];
    end
  end

  // Free-running divider: one filter update per 256 clocks (125 kHz at 32 MHz).
  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      tick_cnt_q <= 8'd0;
      y_q        <= 16'sd0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 8'd1;
      if (tick_cnt_q == 8'hFF) begin
        y_q <= y_d;
      end
    end
  end

  assign audio_out = y_q;
`else
  assign audio_out = audio_raw;
`endif

endmodule

// File: tb/tb_m72_sample_player.sv
`timescale 1ns / 1ps
// Bench for m72_sample_player: directed table, hand-written corner sequences, and random
// pointer traffic checked against an arithmetic pointer/DAC model and an SDRAM model.
module tb_m72_sample_player;

  localparam logic [24:0] BASE = 25'h0123400;
  localparam int unsigned PW   = 18;

  logic        CLK_32M = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  sample_addr_wr = 2'b00;
  logic [7:0]  sample_addr = 8'h00;
  logic        sample_inc = 1'b0;
  logic [7:0]  sample_out = 8'h00;
  logic [7:0]  sample_in;
  logic        sample_ready;
  logic [24:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [15:0] audio_out;

  m72_sample_player #(
    .ROM_BASE(BASE),
    .PTR_W   (PW)
  ) dut (
    .CLK_32M       (CLK_32M),
    .reset_n       (reset_n),
    .sample_addr_wr(sample_addr_wr),
    .sample_addr   (sample_addr),
    .sample_inc    (sample_inc),
    .sample_out    (sample_out),
    .sample_in     (sample_in),
    .sample_ready  (sample_ready),
    .rom_addr      (rom_addr),
    .rom_req       (rom_req),
    .rom_ack       (rom_ack),
    .rom_data      (rom_data),
    .audio_out     (audio_out)
  );

  always #5 CLK_32M = ~CLK_32M;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample ROM contents as a function of the ROM offset; offset 0 holds 8'h3C.
  function automatic logic [7:0] rom_byte(input logic [24:0] a);
    logic [24:0] o;
    logic [7:0]  t;
    o = a - BASE;
    t = o[7:0] * 8'd7 + o[15:8] * 8'd3 + o[23:16];
    return t ^ 8'h3C;
  endfunction

  // SDRAM model: registers the request one cycle, then acks sd_lat cycles later.
  logic       sd_en = 1'b1;
  int         sd_lat = 5;
  int         sd_cnt = 0;
  logic       sd_ack = 1'b0;
  logic [7:0] sd_data = 8'h00;
  logic       man_ack = 1'b0;
  logic [7:0] man_data = 8'h00;

  assign rom_ack  = sd_en ? sd_ack : man_ack;
  assign rom_data = sd_en ? sd_data : man_data;

  always @(negedge CLK_32M) begin
    if (!sd_en || sd_ack) begin
      sd_ack = 1'b0;
      sd_cnt = 0;
    end else if (rom_req) begin
      sd_cnt++;
      if (sd_cnt == sd_lat + 2) begin
        sd_ack  = 1'b1;
        sd_data = rom_byte(rom_addr);
      end
    end else begin
      sd_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic ptr_event(input logic [1:0] wr, input logic [7:0] a, input logic inc,
                           input logic [7:0] so);
    sample_addr_wr = wr;
    sample_addr    = a;
    sample_inc     = inc;
    sample_out     = so;
    tick();
    sample_addr_wr = 2'b00;
    sample_inc     = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sample_ready) break;
      tick();
    end
    check({name, " ready"}, 32'(sample_ready), 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 50; i++) begin
      if (rom_req) break;
      tick();
    end
    check({name, " req"}, 32'(rom_req), 32'd1);
  endtask

  // Reference model state: pointer as a plain integer, DAC value.
  int unsigned m_ptr = 0;
  logic [7:0]  m_dac = 8'h80;

  task automatic model_event(input logic [1:0] wr, input logic [7:0] a, input logic inc,
                             input logic [7:0] so);
    if (wr[0]) m_ptr = (m_ptr / 8192) * 8192 + int'(a) * 32;
    if (wr[1]) m_ptr = (m_ptr % 8192) + (int'(a) % (1 << (PW - 13))) * 8192;
    if (inc) begin
      m_ptr = (m_ptr + 1) % (1 << PW);
      m_dac = so;
    end
  endtask

  function automatic logic [15:0] exp_audio(input logic [7:0] d);
    return 16'((int'(d) - 128) * 256);
  endfunction

  typedef struct {
    logic [1:0]  wr;
    logic [7:0]  a;
    logic        inc;
    logic [7:0]  so;
    logic [17:0] ptr;
    logic [15:0] aud;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int t_req, t_rdy;
    logic low_seen;

    tbl[0] = '{2'b01, 8'h12, 1'b0, 8'h00, 18'h00240, 16'h0000};
    tbl[1] = '{2'b10, 8'h05, 1'b0, 8'h00, 18'h0A240, 16'h0000};
    tbl[2] = '{2'b00, 8'h00, 1'b1, 8'h00, 18'h0A241, 16'h8000};
    tbl[3] = '{2'b11, 8'h3F, 1'b1, 8'h90, 18'h3E7E1, 16'h1000};
    tbl[4] = '{2'b10, 8'hE2, 1'b0, 8'h00, 18'h047E1, 16'h1000};
    tbl[5] = '{2'b01, 8'h00, 1'b1, 8'h7F, 18'h04001, 16'hFF00};
    tbl[6] = '{2'b00, 8'h00, 1'b1, 8'h80, 18'h04002, 16'h0000};

    // Reset state
    repeat (3) tick();
    check("reset rom_req", 32'(rom_req), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'(BASE));
    check("reset sample_in", 32'(sample_in), 32'd0);
    check("reset audio", 32'(audio_out), 32'd0);
    check("reset ready", 32'(sample_ready), 32'd0);

    // First fetch after reset, 5-cycle SDRAM latency
    reset_n = 1'b1;
    t_req = -1;
    t_rdy = -1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rom_req && t_req < 0) t_req = c;
      if (sample_ready) begin
        t_rdy = c;
        break;
      end
    end
    check("first fetch latency", 32'(t_rdy - t_req), 32'd7);
    check("first fetch addr", 32'(rom_addr), 32'(BASE));
    check("first fetch data", 32'(sample_in), 32'h3C);

    // Directed vectors
    foreach (tbl[i]) begin
      ptr_event(tbl[i].wr, tbl[i].a, tbl[i].inc, tbl[i].so);
      check($sformatf("vec%0d ready drop", i), 32'(sample_ready), 32'd0);
      check($sformatf("vec%0d req early", i), 32'(rom_req), 32'd0);
      tick();
      check($sformatf("vec%0d req", i), 32'(rom_req), 32'd1);
      check($sformatf("vec%0d addr", i), 32'(rom_addr), 32'(BASE + 25'(tbl[i].ptr)));
      wait_ready($sformatf("vec%0d", i));
      check($sformatf("vec%0d data", i), 32'(sample_in), 32'(rom_byte(BASE + 25'(tbl[i].ptr))));
`ifndef M72_SAMPLE_FILTER_EN
      check($sformatf("vec%0d audio", i), 32'(audio_out), 32'(tbl[i].aud));
`endif
    end

    // Pointer wrap at 2^PTR_W
    ptr_event(2'b01, 8'hFF, 1'b0, 8'h80);
    ptr_event(2'b10, 8'h1F, 1'b0, 8'h80);
    repeat (31) ptr_event(2'b00, 8'h00, 1'b1, 8'h80);
    wait_ready("wrap pre");
    check("wrap pre addr", 32'(rom_addr), 32'(BASE + 25'h3FFFF));
    ptr_event(2'b00, 8'h00, 1'b1, 8'hFF);
    wait_ready("wrap");
    check("wrap addr", 32'(rom_addr), 32'(BASE));
    check("wrap data", 32'(sample_in), 32'h3C);
`ifndef M72_SAMPLE_FILTER_EN
    check("wrap audio", 32'(audio_out), 32'h7F00);
`endif

    // Pointer load during WAIT: stale data discarded, refetch of new address
    sd_en = 1'b0;
    ptr_event(2'b01, 8'h21, 1'b0, 8'h00);
    wait_req("stale first");
    low_seen = 1'b0;
    ptr_event(2'b01, 8'h33, 1'b0, 8'h00);
    low_seen |= sample_ready;
    tick();
    low_seen |= sample_ready;
    man_ack  = 1'b1;
    man_data = 8'hEE;
    tick();
    man_ack = 1'b0;
    low_seen |= sample_ready;
    check("stale not latched", 32'(sample_in), 32'h3C);
    check("stale req drop", 32'(rom_req), 32'd0);
    tick();
    low_seen |= sample_ready;
    check("stale refetch req", 32'(rom_req), 32'd1);
    check("stale refetch addr", 32'(rom_addr), 32'(BASE + 25'h00660));
    tick();
    low_seen |= sample_ready;
    man_ack  = 1'b1;
    man_data = rom_byte(BASE + 25'h00660);
    tick();
    man_ack = 1'b0;
    check("stale ready low throughout", 32'(low_seen), 32'd0);
    check("stale refetch data", 32'(sample_in), 32'(rom_byte(BASE + 25'h00660)));
    check("stale refetch ready", 32'(sample_ready), 32'd1);

    // Reset while in WAIT, then a stale ack
    ptr_event(2'b01, 8'h44, 1'b0, 8'h00);
    wait_req("rst wait");
    reset_n = 1'b0;
    tick();
    check("rst wait req", 32'(rom_req), 32'd0);
    check("rst wait sample_in", 32'(sample_in), 32'd0);
    check("rst wait audio", 32'(audio_out), 32'd0);
    tick();
    reset_n  = 1'b1;
    man_ack  = 1'b1;
    man_data = 8'h99;
    tick();
    man_ack = 1'b0;
    check("rst stale ack ignored", 32'(sample_in), 32'd0);
    check("rst refetch req", 32'(rom_req), 32'd1);
    check("rst refetch addr", 32'(rom_addr), 32'(BASE));
    sd_en = 1'b1;
    wait_ready("rst refetch");
    check("rst refetch data", 32'(sample_in), 32'h3C);

    // Randomised traffic against the reference model
    m_ptr = 0;
    m_dac = 8'h80;
    for (int t = 0; t < 150; t++) begin
      int nev;
      sd_lat = $urandom_range(0, 6);
      nev = $urandom_range(1, 3);
      for (int e = 0; e < nev; e++) begin
        logic [1:0] wr;
        logic [7:0] a, so;
        logic       inc;
        wr  = 2'($urandom);
        a   = 8'($urandom);
        inc = 1'($urandom);
        so  = 8'($urandom);
        model_event(wr, a, inc, so);
        ptr_event(wr, a, inc, so);
        repeat ($urandom_range(0, 4)) tick();
      end
      wait_ready($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d addr", t), 32'(rom_addr), 32'(BASE + 25'(m_ptr)));
      check($sformatf("rnd%0d data", t), 32'(sample_in), 32'(rom_byte(BASE + 25'(m_ptr))));
`ifndef M72_SAMPLE_FILTER_EN
      check($sformatf("rnd%0d audio", t), 32'(audio_out), 32'(exp_audio(m_dac)));
`endif
    end

`ifdef M72_SAMPLE_FILTER_EN
    begin
      logic [15:0] prev;
      logic        mono;
      ptr_event(2'b00, 8'h00, 1'b1, 8'h80);
      repeat (100 * 256) tick();
      prev = audio_out;
      mono = 1'b1;
      ptr_event(2'b00, 8'h00, 1'b1, 8'hFF);
      repeat (80 * 256) begin
        tick();
        if ($signed(audio_out) < $signed(prev)) mono = 1'b0;
        prev = audio_out;
      end
      check("filter monotonic", 32'(mono), 32'd1);
      check("filter settled", 32'((16'h7F00 - audio_out) <= 16'd7), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/m72_sample_player.md
# m72_sample_player

Responder for the sound CPU's ADPCM-less sample port on M72/M84 boards: holds the sample ROM pointer, prefetches the byte at that pointer from SDRAM, and drives the 8-bit sample DAC. Sits beside `sound`, consuming its `sample_addr_wr`/`sample_addr`/`sample_inc`/`sample_out` strobes and returning `sample_in`/`sample_ready`. It also presents a 16-bit signed audio channel to the mixer.

## Interface
- `ROM_BASE`, 25'h0, SDRAM byte address of sample ROM byte 0.
- `PTR_W`, 18, sample pointer width; pointer wraps modulo 2^PTR_W. Legal range 14..21.
- `CLK_32M` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low; clock CLK_32M.
- `sample_addr_wr` in 2: one-cycle strobe; bit0 = load pointer low byte, bit1 = load pointer high byte.
- `sample_addr` in 8: data for pointer loads.
- `sample_inc` in 1: one-cycle strobe; latch `sample_out` into DAC and advance pointer.
- `sample_out` in 8: unsigned DAC value, valid with `sample_inc`.
- `sample_in` out 8: ROM byte at current pointer.
- `sample_ready` out 1: high when `sample_in` matches current pointer and no fetch is pending.
- `rom_addr` out 25: SDRAM byte address = ROM_BASE + pointer.
- `rom_req` out 1: level request; held until `rom_ack`.
- `rom_ack` in 1: one-cycle pulse; `rom_data` valid same cycle.
- `rom_data` in 8: SDRAM read data.
- `audio_out` out 16: signed DAC output.

## Operation
- Pointer `ptr[PTR_W-1:0]`, reset 0.
  - Low load: `ptr[12:5] <= sample_addr`, `ptr[4:0] <= 0`, upper bits kept.
  - High load: `ptr[PTR_W-1:13] <= sample_addr[PTR_W-14:0]`; excess data bits ignored; low bits kept.
  - Increment: `ptr <= ptr + 1`, wrapping to 0 at 2^PTR_W.
  - Same-cycle events apply in order low load, high load, increment.
- Any pointer event sets `dirty`.
- Fetch FSM:
  - IDLE: if `dirty`, clear `dirty`, drive `rom_addr` from `ptr`, raise `rom_req`, go to WAIT.
  - WAIT: hold `rom_req` and `rom_addr`. On `rom_ack`, drop `rom_req`. If `dirty` was set during the wait, discard `rom_data` and go to IDLE, which refetches. Otherwise latch `sample_in <= rom_data` and go to IDLE.
  - `rom_ack` in IDLE is ignored.
- `sample_ready = (state==IDLE) & ~dirty`.
- DAC: on `sample_inc`, `dac <= sample_out`. `audio_out = {dac ^ 8'h80, 8'h00}` (0x80 = silence = 0).

## Timing
- Reset values: `ptr`=0, `sample_in`=0, `rom_req`=0, `rom_addr`=ROM_BASE, `dac`=8'h80, `audio_out`=0.
- After reset `dirty`=1, so the byte at pointer 0 is fetched and `sample_ready` stays low until it arrives.
- Pointer event at cycle N: `ptr` updates at N+1. `sample_ready` is low from N+1. `rom_req` rises at N+2 with the new `rom_addr`.
- Ack at cycle M with no new event: `sample_in` valid and `sample_ready` high at M+1; `rom_req` low at M+1.
- Fetch latency = 2 + SDRAM latency cycles.
- Reset while in WAIT: `rom_req` drops next cycle and the FSM returns to IDLE with `dirty`=1. A stale ack is ignored.
- `sound` gates its Z80 CEN with `sample_ready`, so `sample_in` is never read stale.

## Configuration
- `M72_SAMPLE_FILTER_EN` defined:
  - `audio_out` is a one-pole low-pass of the raw DAC value: `y <= y + ((x - y) >>> 3)`.
  - Updated once every 256 clocks (125 kHz tick from an 8-bit free-running counter).
  - 16-bit signed arithmetic, saturated.
  - `y` resets to 0.
- Not defined: `audio_out` equals the raw value combinationally from `dac`; no counter is instantiated.

## Test plan
- Reset, SDRAM model with 5-cycle ack latency, ROM[0]=8'h3C -> `rom_addr`=ROM_BASE; `sample_ready` rises 7 cycles after `rom_req`; `sample_in`=8'h3C.
- Low load 8'h12 then high load 8'h05 -> `ptr`=18'h0A240, `rom_addr`=ROM_BASE+18'h0A240, and `sample_in` equals that ROM byte.
- `ptr`=18'h3FFFF, then `sample_inc` with `sample_out`=8'hFF -> `ptr`=0, `audio_out`=16'h7F00, refetch of byte 0.
- Low load during WAIT, with ack arriving 2 cycles later -> stale data is not latched; a second `rom_req` goes to the new address; `sample_ready` is low throughout.
- Reset asserted in WAIT, then ack pulsed -> `rom_req`=0 and `sample_in` unchanged (0); a fresh fetch of address 0 follows.
- With `M72_SAMPLE_FILTER_EN`, step DAC from 8'h80 to 8'hFF -> `audio_out` rises monotonically over 125 kHz ticks, reaching within 1 LSB-step of 16'h7F00 after about 60 ticks.
